grid_state_monitor: RTL
=======================

Name: grid_state_monitor

Overview:
- Upstream classifier feeding the sc_connection interface: turns periodic grid-voltage samples into the debounced grid_state consumed by the safety logic and the charging FSM.
- Applies thresholds with hysteresis, an N-sample debounce, a fail-safe outage path and a missing-sample watchdog.
- Sole driver of grid_state.

Parameters:
- DW, 12, sample width (unsigned voltage code)
- V_OUT_TH, 400, below this the sample is classed OUTAGE
- V_SAG_TH, 1800, below this the sample is classed SAG
- V_SWELL_TH, 2400, above this the sample is classed SWELL
- HYST, 32, hysteresis band for leaving a fault state
- DEBOUNCE, 4, consecutive agreeing samples needed to commit a non-OUTAGE state (>=1)
- TIMEOUT_CYC, 1024, clk cycles without sample_valid before forcing OUTAGE

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe; v_sample is valid this cycle
- v_sample  in  DW  RMS voltage code
- grid_state  out  2  grid_state_t: NORMAL=2'b00, SAG=2'b01, SWELL=2'b10, OUTAGE=2'b11
- state_valid  out  1  high once a first state has been committed since reset
- state_change  out  1  one-cycle pulse when grid_state changes value
- sag_cnt  out  8  SAG entry count (optional feature)
- swell_cnt  out  8  SWELL entry count (optional feature)
- outage_cnt  out  8  OUTAGE entry count (optional feature)

Behaviour:
- Single clock domain.
- Reset is asynchronous active-low. In reset: grid_state=OUTAGE, state_valid=0, state_change=0, all counters=0. This is the fail-safe default.
- Raw class per valid sample, in priority order:
  - v < V_OUT_TH gives OUTAGE.
  - v < V_SAG_TH gives SAG.
  - v > V_SWELL_TH gives SWELL.
  - Otherwise NORMAL.
- Hysteresis on exit, based on the committed state:
  - SAG is held (raw forced to SAG) while v < V_SAG_TH+HYST.
  - SWELL is held while v > V_SWELL_TH-HYST.
  - OUTAGE is held while v < V_OUT_TH+HYST.
  - Hysteresis does not apply while state_valid=0.
  - Threshold sums and differences are computed at DW+1 bits; there is no wrap.
- Debounce:
  - A candidate register and a counter (width clog2(DEBOUNCE+1)) track agreement.
  - Raw equal to the committed state with state_valid=1: counter cleared.
  - Raw differing from the candidate: candidate=raw, counter=1.
  - Raw equal to the candidate: counter increments, saturating at DEBOUNCE.
  - The commit fires on the edge where the counter reaches DEBOUNCE. grid_state updates on the clk edge that samples the completing sample_valid (1-cycle latency).
- OUTAGE fast path:
  - A raw OUTAGE sample commits OUTAGE immediately, with no debounce, on the same edge. The debounce counter is cleared.
  - If the device is in reset-initial OUTAGE with state_valid=0, the first raw OUTAGE sets state_valid=1 with no state_change.
- Watchdog:
  - The cycle counter clears on each sample_valid and otherwise increments, saturating.
  - When it reaches TIMEOUT_CYC, grid_state is forced to OUTAGE and the debounce counter is cleared. state_valid is unchanged.
  - A sample_valid in the same cycle as the timeout wins: the sample is processed and no timeout fires.
- state_change:
  - Pulses for exactly one cycle coincident with the updated grid_state, only when the value differs from the old one.
  - It also pulses on the first commit after reset when the committed state is not OUTAGE.
- Never more than one transition per cycle. No direct SAG-to-SWELL short-cut is needed: the debounce governs all non-OUTAGE moves.
- Reset mid-debounce discards the candidate and the count.

Optional Feature:
- GRID_MON_STATS_EN defined: sag_cnt, swell_cnt and outage_cnt each increment, saturating at 255, on every commit into SAG, SWELL or OUTAGE respectively. Watchdog-forced OUTAGE counts. Counters clear only on reset.
- Not defined: the three ports are driven constant 0 and no counter logic is synthesised.

Test Plan:
- Reset, then 4 samples of 2048 spaced 10 cycles apart: after the 4th edge, state_valid=1, grid_state=00, state_change pulses 1 cycle; grid_state=11 before that.
- From NORMAL: 3x1700, 1x2048, 3x1700: grid_state stays 00. Then a 4th consecutive 1700: grid_state=01 plus pulse.
- In SAG: 6x1810 keeps 01 (inside the 1832 hysteresis). Then 4x1840 gives 00. Separately, from NORMAL, 4x2500 gives 10, and 2380 keeps 10.
- From NORMAL, a single sample of 300: grid_state=11 on the next edge, state_change=1; with GRID_MON_STATS_EN, outage_cnt=1.
- After NORMAL, withhold sample_valid for 1024 cycles: grid_state=11 at the 1024th cycle, state_valid stays 1. Then 4x2048 restores 00.
- Assert reset_n low after 2 of 4 NORMAL samples: grid_state=11, state_valid=0 immediately. After release, 4 fresh samples are needed to commit.

Source files
------------

// File: rtl/grid_state_monitor.sv
// grid_state_monitor: classifies periodic grid-voltage samples into a
// debounced grid_state (NORMAL/SAG/SWELL/OUTAGE). It applies hysteresis on
// exit from fault states, has an immediate OUTAGE path, and includes a
// missing-sample watchdog that forces OUTAGE.
// Optional build macro GRID_MON_STATS_EN enables the saturating per-state
// entry counters. Without it, the counter ports are tied to zero.
module grid_state_monitor #(
  parameter int DW          = 12,
  parameter int V_OUT_TH    = 400,
  parameter int V_SAG_TH    = 1800,
  parameter int V_SWELL_TH  = 2400,
  parameter int HYST        = 32,
  parameter int DEBOUNCE    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sample_valid,
  input  logic [DW-1:0] v_sample,
  output logic [1:0]    grid_state,
  output logic          state_valid,
  output logic          state_change,
  output logic [7:0]    sag_cnt,
  output logic [7:0]    swell_cnt,
  output logic [7:0]    outage_cnt
);

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    SAG    = 2'b01,
    SWELL  = 2'b10,
    OUTAGE = 2'b11
  } grid_state_t;

  // Thresholds use one extra bit so that adding or subtracting HYST cannot wrap.
  localparam int DW1 = DW + 1;
  localparam logic [DW:0] OUT_TH   = DW1'(V_OUT_TH);
  localparam logic [DW:0] SAG_TH   = DW1'(V_SAG_TH);
  localparam logic [DW:0] SWELL_TH = DW1'(V_SWELL_TH);
  localparam logic [DW:0] OUT_HI   = DW1'(V_OUT_TH + HYST);
  localparam logic [DW:0] SAG_HI   = DW1'(V_SAG_TH + HYST);
  localparam logic [DW:0] SWELL_LO = DW1'(V_SWELL_TH - HYST);

  localparam int DCW = $clog2(DEBOUNCE + 1);
  localparam logic [DCW-1:0] DMAX = DCW'(DEBOUNCE);
  localparam logic [DCW-1:0] DONE = DCW'(1);

  localparam int WCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WCW-1:0] WMAX  = WCW'(TIMEOUT_CYC);
  localparam logic [WCW-1:0] WFIRE = WCW'(TIMEOUT_CYC - 1);

  grid_state_t    gs_q, gs_n, cand, cand_n, raw_base, raw;
  logic           sv_n;
  logic [DCW-1:0] dcnt, dcnt_n, dcnt_new;
  logic [WCW-1:0] wd_cnt, wd_n;
  logic [DW:0]    vx;

  // Raw class of the current sample. Hysteresis holds a committed fault
  // state, but a true OUTAGE reading always takes priority.
  always_comb begin
    vx = {1'b0, v_sample};
    if (vx < OUT_TH)        raw_base = OUTAGE;
    else if (vx < SAG_TH)   raw_base = SAG;
    else if (vx > SWELL_TH) raw_base = SWELL;
    else                    raw_base = NORMAL;
    raw = raw_base;
    if (state_valid && raw_base != OUTAGE) begin
      case (gs_q)
        SAG:     if (vx < SAG_HI)   raw = SAG;
        SWELL:   if (vx > SWELL_LO) raw = SWELL;
        OUTAGE:  if (vx < OUT_HI)   raw = OUTAGE;
        default: ;
      endcase
    end
  end

  // Next-state logic covers debounce, the OUTAGE fast path and the watchdog.
  // A sample arriving in the timeout cycle suppresses the timeout.
  always_comb begin
    gs_n     = gs_q;
    sv_n     = state_valid;
    cand_n   = cand;
    dcnt_n   = dcnt;
    dcnt_new = (raw != cand) ? DONE : ((dcnt == DMAX) ? dcnt : dcnt + DONE);
    wd_n     = sample_valid ? '0 : ((wd_cnt == WMAX) ? wd_cnt : wd_cnt + 1'b1);
    if (sample_valid) begin
      if (raw == OUTAGE) begin
        gs_n   = OUTAGE;
        sv_n   = 1'b1;
        cand_n = OUTAGE;
        dcnt_n = '0;
      end else if (state_valid && raw == gs_q) begin
        dcnt_n = '0;
      end else begin
        cand_n = raw;
        dcnt_n = dcnt_new;
        if (dcnt_new == DMAX) begin
          gs_n = raw;
          sv_n = 1'b1;
        end
      end
    end else if (wd_cnt == WFIRE) begin
      gs_n   = OUTAGE;
      dcnt_n = '0;
    end
  end

  // Registered state. Reset puts the block in the fail-safe OUTAGE state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gs_q         <= OUTAGE;
      state_valid  <= 1'b0;
      state_change <= 1'b0;
      cand         <= OUTAGE;
      dcnt         <= '0;
      wd_cnt       <= '0;
    end else begin
      gs_q         <= gs_n;
      state_valid  <= sv_n;
      state_change <= (gs_n != gs_q);
      cand         <= cand_n;
      dcnt         <= dcnt_n;
      wd_cnt       <= wd_n;
    end
  end

  assign grid_state = gs_q;

`ifdef GRID_MON_STATS_EN
  // Entry counters increment on each change into a fault state and saturate at 255.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sag_cnt    <= '0;
      swell_cnt  <= '0;
      outage_cnt <= '0;
    end else if (gs_n != gs_q) begin
      if (gs_n == SAG    && sag_cnt    != 8'hFF) sag_cnt    <= sag_cnt + 8'd1;
      if (gs_n == SWELL  && swell_cnt  != 8'hFF) swell_cnt  <= swell_cnt + 8'd1;
      if (gs_n == OUTAGE && outage_cnt != 8'hFF) outage_cnt <= outage_cnt + 8'd1;
    end
  end
`else
  assign sag_cnt    = 8'd0;
  assign swell_cnt  = 8'd0;
  assign outage_cnt = 8'd0;
`endif

endmodule
